// File: rtl/adc_pll_sup_pkg.sv
// Shared definitions for the ADC PLL lock supervisor.
//   sup_state_e : supervisor FSM state encoding (also exported on state_o)
//   tmr_width() : width of the shared sequencing counter for a parameter set
package adc_pll_sup_pkg;

    typedef enum logic [2:0] {
        ST_RESET_PLL = 3'd0,
        ST_WAIT_LOCK = 3'd1,
        ST_STABLE    = 3'd2,
        ST_RUN       = 3'd3,
        ST_FAULT     = 3'd4
    } sup_state_e;

    // The counter is reloaded with (cycles - 1), so clog2(max) bits hold every load value.
    function automatic int unsigned tmr_width(input int unsigned rst_cycles,
                                              input int unsigned lock_timeout,
                                              input int unsigned stable_cycles);
        int unsigned m;
        m = (rst_cycles > lock_timeout) ? rst_cycles : lock_timeout;
        m = (m > stable_cycles) ? m : stable_cycles;
        return (m < 2) ? 1 : $clog2(m);
    endfunction

endpackage

// File: rtl/adc_pll_lock_supervisor_sync.sv
// Two-flop synchronizer for a single asynchronous level.
//   refclk : destination clock
//   rst_n  : async active-low reset, clears both flops
//   i_d    : asynchronous input
//   o_q    : synchronized output (2 refclk edges of latency)
module sync_2ff (
    input  logic refclk,
    input  logic rst_n,
    input  logic i_d,
    output logic o_q
);

    logic r_meta;
    logic r_sync;

    always_ff @(posedge refclk or negedge rst_n) begin
        if (!rst_n) begin
            r_meta <= 1'b0;
            r_sync <= 1'b0;
        end else begin
            r_meta <= i_d;
            r_sync <= r_meta;
        end
    end

    assign o_q = r_sync;

endmodule

// File: rtl/adc_pll_lock_supervisor.sv
// Supervises the ADC clock PLL: pulses its reset, qualifies the asynchronous
// locked flag, declares the ADC clock ready after a stable lock, retries on
// timeouts and counts lock losses seen while running.
//   refclk        : 50 MHz reference clock (only clock)
//   rst_n         : async active-low reset
//   pll_locked    : PLL lock flag, asynchronous
//   restart       : one-cycle request to restart sequencing / clear fault
//   pll_rst       : PLL reset, active high
//   adc_ready     : ADC clock usable (state RUN)
//   fault         : lock retries exhausted
//   lock_loss_cnt : saturating count of lock losses in RUN
//   state_o       : current FSM state, for debug
module adc_pll_lock_supervisor
    import adc_pll_sup_pkg::*;
#(
    parameter int unsigned RST_CYCLES    = 16,
    parameter int unsigned LOCK_TIMEOUT  = 50000,
    parameter int unsigned STABLE_CYCLES = 1024,
    parameter int unsigned MAX_RETRIES   = 7,
    parameter int unsigned CNT_W         = 8
) (
    input  logic             refclk,
    input  logic             rst_n,
    input  logic             pll_locked,
    input  logic             restart,
    output logic             pll_rst,
    output logic             adc_ready,
    output logic             fault,
    output logic [CNT_W-1:0] lock_loss_cnt,
    output logic [2:0]       state_o
);

    localparam int unsigned TMR_W = tmr_width(RST_CYCLES, LOCK_TIMEOUT, STABLE_CYCLES);
    localparam int unsigned RTY_W = $clog2(MAX_RETRIES + 1);

    localparam logic [TMR_W-1:0] TMR_RST    = TMR_W'(RST_CYCLES - 1);
    localparam logic [TMR_W-1:0] TMR_LOCK   = TMR_W'(LOCK_TIMEOUT - 1);
    localparam logic [TMR_W-1:0] TMR_STABLE = TMR_W'(STABLE_CYCLES - 1);
    localparam logic [RTY_W-1:0] RTY_MAX    = RTY_W'(MAX_RETRIES);

    logic             w_locked_s;
    sup_state_e       r_state;
    sup_state_e       w_next_state;
    logic [TMR_W-1:0] r_tmr;
    logic [TMR_W-1:0] w_tmr_next;
    logic [RTY_W-1:0] r_retry_cnt;
    logic [RTY_W-1:0] w_retry_next;
    logic [RTY_W-1:0] w_retry_inc;
    logic [CNT_W-1:0] r_loss_cnt;
    logic [CNT_W-1:0] w_loss_next;
    logic             r_pll_rst;
    logic             r_adc_ready;
    logic             r_fault;

    sync_2ff u_sync_locked (
        .refclk (refclk),
        .rst_n  (rst_n),
        .i_d    (pll_locked),
        .o_q    (w_locked_s)
    );

    assign w_retry_inc = r_retry_cnt + RTY_W'(1);

    // Next-state, counter and bookkeeping logic
    always_comb begin
        w_next_state = r_state;
        w_tmr_next   = r_tmr;
        w_retry_next = r_retry_cnt;
        w_loss_next  = r_loss_cnt;

        if (restart) begin
            // Overrides everything, including an uncounted lock loss in RUN
            w_next_state = ST_RESET_PLL;
            w_retry_next = '0;
        end else begin
            case (r_state)
                ST_RESET_PLL: begin
                    if (r_tmr == '0) w_next_state = ST_WAIT_LOCK;
                    else             w_tmr_next   = r_tmr - TMR_W'(1);
                end
                ST_WAIT_LOCK: begin
                    if (w_locked_s) begin
                        w_next_state = ST_STABLE;
                    end else if (r_tmr == '0) begin
                        w_retry_next = w_retry_inc;
                        w_next_state = (w_retry_inc == RTY_MAX) ? ST_FAULT : ST_RESET_PLL;
                    end else begin
                        w_tmr_next = r_tmr - TMR_W'(1);
                    end
                end
                ST_STABLE: begin
                    if (!w_locked_s) begin
                        w_next_state = ST_WAIT_LOCK;
                    end else if (r_tmr == '0) begin
                        w_next_state = ST_RUN;
                        w_retry_next = '0;
                    end else begin
                        w_tmr_next = r_tmr - TMR_W'(1);
                    end
                end
                ST_RUN: begin
                    if (!w_locked_s) begin
                        w_next_state = ST_RESET_PLL;
                        if (r_loss_cnt != '1) w_loss_next = r_loss_cnt + CNT_W'(1);
                    end
                end
                ST_FAULT: begin
                    w_next_state = ST_FAULT;
                end
                default: begin
                    w_next_state = ST_RESET_PLL;
                end
            endcase
        end

        // Reload the shared counter on every state entry (restart counts as re-entry)
        if (restart || (w_next_state != r_state)) begin
            case (w_next_state)
                ST_RESET_PLL: w_tmr_next = TMR_RST;
                ST_WAIT_LOCK: w_tmr_next = TMR_LOCK;
                ST_STABLE:    w_tmr_next = TMR_STABLE;
                default:      w_tmr_next = '0;
            endcase
        end
    end

    // State, counters and outputs; outputs decode the next state so they change with it
    always_ff @(posedge refclk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= ST_RESET_PLL;
            r_tmr       <= TMR_RST;
            r_retry_cnt <= '0;
            r_loss_cnt  <= '0;
            r_pll_rst   <= 1'b1;
            r_adc_ready <= 1'b0;
            r_fault     <= 1'b0;
        end else begin
            r_state     <= w_next_state;
            r_tmr       <= w_tmr_next;
            r_retry_cnt <= w_retry_next;
            r_loss_cnt  <= w_loss_next;
            r_pll_rst   <= (w_next_state == ST_RESET_PLL) || (w_next_state == ST_FAULT);
            r_adc_ready <= (w_next_state == ST_RUN);
            r_fault     <= (w_next_state == ST_FAULT);
        end
    end

    assign pll_rst       = r_pll_rst;
    assign adc_ready     = r_adc_ready;
    assign fault         = r_fault;
    assign lock_loss_cnt = r_loss_cnt;
    assign state_o       = r_state;

endmodule
